pacman_game_ctrl: RTL and testbench

Parametrised successor to the PacMan game-state controller. It owns the score, the fruit-eaten mask and the lives counter internally, and detects overlap against N ghosts and N fruits with true bounding boxes. It adds a multi-life death/respawn sequence on top of that. It sits between the keycode/sprite-position logic and the display/sprite modules, which consume its status and control pulses.

---
 rtl/pacman_game_ctrl_pkg.sv | 30 +++
 rtl/pacman_game_ctrl_if.sv | 48 ++++
 rtl/pacman_game_ctrl_aabb.sv | 31 +++
 rtl/pacman_game_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pacman_game_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_game_ctrl_pkg.sv
// rtl/pacman_game_ctrl_pkg.sv - game-state encoding and USB key codes for the PacMan controller
//
// Contents:
//   game_state_t  - controller state encoding (all eight 3-bit codes are named)
//   KEY_*         - USB HID keycodes for the four move keys and the restart key
//   is_move_key   - true for any of the four move keys
package pacman_pkg;

    typedef enum logic [2:0] {
        RESTART   = 3'd0,
        PAUSE     = 3'd1,
        RUN       = 3'd2,
        EAT       = 3'd3,
        DEATH     = 3'd4,
        RESPAWN   = 3'd5,
        GAME_OVER = 3'd6,
        GAME_WON  = 3'd7
    } game_state_t;

    localparam logic [7:0] KEY_W   = 8'h1A;
    localparam logic [7:0] KEY_A   = 8'h04;
    localparam logic [7:0] KEY_S   = 8'h16;
    localparam logic [7:0] KEY_D   = 8'h07;
    localparam logic [7:0] KEY_ESC = 8'h29;

    function automatic logic is_move_key(input logic [7:0] key);
        return (key == KEY_W) || (key == KEY_A) || (key == KEY_S) || (key == KEY_D);
    endfunction

endpackage

// File: rtl/pacman_game_ctrl_if.sv
// rtl/pacman_game_ctrl_if.sv - sprite geometry / keycode in, game status out
//
// Signals:
//   keycode            - current USB keycode
//   pX, pY, pSize      - PacMan top-left corner and edge length
//   gX, gY, gSize      - packed ghost corners (ghost i at [i*COORD_W +: COORD_W]) and edge length
//   fX, fY, fSize      - packed fruit corners and edge length
//   score, fruits_eaten, lives           - game status
//   running, win, lose, restart, respawn, lifeDown - Moore state flags
// Modports:
//   master - keycode/sprite-position side (drives geometry, reads status)
//   slave  - the game controller
interface pacman_game_ctrl_if #(
    parameter int N_GHOSTS = 3,
    parameter int N_FRUITS = 4,
    parameter int COORD_W  = 10,
    parameter int SCORE_W  = 10
) ();
    logic [7:0]                   keycode;
    logic [COORD_W-1:0]           pX;
    logic [COORD_W-1:0]           pY;
    logic [COORD_W-1:0]           pSize;
    logic [N_GHOSTS*COORD_W-1:0]  gX;
    logic [N_GHOSTS*COORD_W-1:0]  gY;
    logic [COORD_W-1:0]           gSize;
    logic [N_FRUITS*COORD_W-1:0]  fX;
    logic [N_FRUITS*COORD_W-1:0]  fY;
    logic [COORD_W-1:0]           fSize;
    logic [SCORE_W-1:0]           score;
    logic [N_FRUITS-1:0]          fruits_eaten;
    logic [2:0]                   lives;
    logic                         running;
    logic                         win;
    logic                         lose;
    logic                         restart;
    logic                         respawn;
    logic                         lifeDown;

    modport master (
        output keycode, pX, pY, pSize, gX, gY, gSize, fX, fY, fSize,
        input  score, fruits_eaten, lives, running, win, lose, restart, respawn, lifeDown
    );

    modport slave (
        input  keycode, pX, pY, pSize, gX, gY, gSize, fX, fY, fSize,
        output score, fruits_eaten, lives, running, win, lose, restart, respawn, lifeDown
    );
endinterface

// File: rtl/pacman_game_ctrl_aabb.sv
// rtl/pacman_game_ctrl_aabb.sv - combinational axis-aligned square overlap test
//
// Ports:
//   ax, ay, a_size - box A top-left corner and edge length
//   bx, by, b_size - box B top-left corner and edge length
//   hit            - 1 when the interiors overlap; boxes that only share an edge do not
module aabb_overlap #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] a_size,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] b_size,
    output logic               hit
);
    // One extra bit so a sprite near the right/bottom edge does not wrap to a small end coordinate.
    logic [COORD_W:0] a_x_end;
    logic [COORD_W:0] a_y_end;
    logic [COORD_W:0] b_x_end;
    logic [COORD_W:0] b_y_end;

    assign a_x_end = {1'b0, ax} + {1'b0, a_size};
    assign a_y_end = {1'b0, ay} + {1'b0, a_size};
    assign b_x_end = {1'b0, bx} + {1'b0, b_size};
    assign b_y_end = {1'b0, by} + {1'b0, b_size};

    assign hit = ({1'b0, ax} < b_x_end) && ({1'b0, bx} < a_x_end) &&
                 ({1'b0, ay} < b_y_end) && ({1'b0, by} < a_y_end);
endmodule

// File: rtl/pacman_game_ctrl.sv
// rtl/pacman_game_ctrl.sv - PacMan game-state controller with score, fruits, lives and respawn
//
// Ports:
//   Clk     - system clock
//   Reset_n - asynchronous active-low reset
//   bus     - pacman_game_ctrl_if.slave: keycode and sprite geometry in,
//             score / fruits_eaten / lives and Moore state flags out
module pacman_game_ctrl
    import pacman_pkg::*;
#(
    parameter int N_GHOSTS       = 3,
    parameter int N_FRUITS       = 4,
    parameter int COORD_W        = 10,
    parameter int SCORE_W        = 10,
    parameter int FRUIT_POINTS   = 50,
    parameter int WIN_SCORE      = 200,
    parameter int LIVES          = 3,
    parameter int RESPAWN_CYCLES = 1024
) (
    input  logic              Clk,
    input  logic              Reset_n,
    pacman_game_ctrl_if.slave bus
);
    localparam int FIDX_W = (N_FRUITS > 1) ? $clog2(N_FRUITS) : 1;
    localparam int CNT_W  = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    // Score arithmetic is done wide enough that neither FRUIT_POINTS nor WIN_SCORE is truncated.
    localparam int SUM_W  = ((SCORE_W > 31) ? SCORE_W : 31) + 1;

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RESPAWN_CYCLES - 1);
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});
    localparam logic [SUM_W-1:0] POINTS    = SUM_W'(FRUIT_POINTS);
    localparam logic [SUM_W-1:0] WIN_AT    = SUM_W'(WIN_SCORE);

    game_state_t state;
    game_state_t state_nxt;

    logic [SCORE_W-1:0]  score_q;
    logic [N_FRUITS-1:0] eaten_q;
    logic [2:0]          lives_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [FIDX_W-1:0]   idx_q;

    logic [N_GHOSTS-1:0] ghost_ov;
    logic [N_FRUITS-1:0] fruit_ov;
    logic [N_FRUITS-1:0] fruit_cand;
    logic                ghost_hit;
    logic                fruit_hit;
    logic [FIDX_W-1:0]   fruit_idx;

    logic [SUM_W-1:0]    score_sum;
    logic [SCORE_W-1:0]  score_inc;
    logic                score_win;
    logic                key_esc;
    logic                key_move;

    for (genvar g = 0; g < N_GHOSTS; g++) begin : g_ghost
        aabb_overlap #(.COORD_W(COORD_W)) u_ov (
            .ax     (bus.pX),
            .ay     (bus.pY),
            .a_size (bus.pSize),
            .bx     (bus.gX[g*COORD_W +: COORD_W]),
            .by     (bus.gY[g*COORD_W +: COORD_W]),
            .b_size (bus.gSize),
            .hit    (ghost_ov[g])
        );
    end

    for (genvar f = 0; f < N_FRUITS; f++) begin : g_fruit
        aabb_overlap #(.COORD_W(COORD_W)) u_ov (
            .ax     (bus.pX),
            .ay     (bus.pY),
            .a_size (bus.pSize),
            .bx     (bus.fX[f*COORD_W +: COORD_W]),
            .by     (bus.fY[f*COORD_W +: COORD_W]),
            .b_size (bus.fSize),
            .hit    (fruit_ov[f])
        );
    end

    // Already-eaten fruits stay on the overlap map but can no longer score.
    assign fruit_cand = fruit_ov & ~eaten_q;
    assign ghost_hit  = |ghost_ov;
    assign fruit_hit  = |fruit_cand;

    // Lowest-index candidate wins: scan downwards so the last assignment is the lowest set bit.
    always_comb begin
        fruit_idx = '0;
        for (int i = N_FRUITS - 1; i >= 0; i--) begin
            if (fruit_cand[i]) begin
                fruit_idx = FIDX_W'(i);
            end
        end
    end

    assign score_sum = SUM_W'(score_q) + POINTS;
    assign score_inc = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    assign score_win = (SUM_W'(score_q) >= WIN_AT);
    assign key_esc   = (bus.keycode == KEY_ESC);
    assign key_move  = is_move_key(bus.keycode);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RESTART;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RESTART: state_nxt = PAUSE;
            PAUSE: begin
                if (key_move) begin
                    state_nxt = RUN;
                end else if (key_esc) begin
                    state_nxt = RESTART;
                end
            end
            RUN: begin
                // Ghost is checked before fruit: a simultaneous hit is a death and the fruit survives.
                if (key_esc) begin
                    state_nxt = RESTART;
                end else if (score_win) begin
                    state_nxt = GAME_WON;
                end else if (ghost_hit) begin
                    state_nxt = DEATH;
                end else if (fruit_hit) begin
                    state_nxt = EAT;
                end
            end
            EAT:   state_nxt = RUN;
            DEATH: state_nxt = (lives_q <= 3'd1) ? GAME_OVER : RESPAWN;
            RESPAWN: begin
                if (key_esc) begin
                    state_nxt = RESTART;
                end else if (cnt_q == '0) begin
                    state_nxt = PAUSE;
                end
            end
            GAME_OVER, GAME_WON: begin
                if (key_esc) begin
                    state_nxt = RESTART;
                end
            end
            default: state_nxt = RESTART;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q <= '0;
            eaten_q <= '0;
            lives_q <= 3'(LIVES);
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state)
                RESTART: begin
                    score_q <= '0;
                    eaten_q <= '0;
                    lives_q <= 3'(LIVES);
                end
                // Captured every RUN cycle; only meaningful on the cycle that moves to EAT.
                RUN: idx_q <= fruit_idx;
                EAT: begin
                    eaten_q <= eaten_q | (N_FRUITS'(1) << idx_q);
                    score_q <= score_inc;
                end
                DEATH: begin
                    lives_q <= lives_q - 3'd1;
                    cnt_q   <= CNT_LOAD;
                end
                RESPAWN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.score        = score_q;
    assign bus.fruits_eaten = eaten_q;
    assign bus.lives        = lives_q;
    assign bus.running      = (state == RUN);
    assign bus.win          = (state == GAME_WON);
    assign bus.lose         = (state == GAME_OVER);
    assign bus.restart      = (state == RESTART);
    assign bus.respawn      = (state == RESPAWN);
    assign bus.lifeDown     = (state == DEATH);
endmodule

// File: tb/tb_pacman_game_ctrl.sv
// tb/tb_pacman_game_ctrl.sv - self-checking bench for pacman_game_ctrl
module tb_pacman_game_ctrl;
    import pacman_pkg::*;

    localparam int NG = 3, NF = 4, CW = 10, SW = 10, PTS = 50, WIN = 200, LV = 3, RC = 1024;
    localparam int SMAX = (1 << SW) - 1;
    localparam int M_RESTART = 0, M_PAUSE = 1, M_RUN = 2, M_EAT = 3;
    localparam int M_DEATH = 4, M_RESPAWN = 5, M_OVER = 6, M_WON = 7;

    logic Clk = 1'b0;
    logic Reset_n;
    logic Reset6_n;
    always #5 Clk = ~Clk;

    pacman_game_ctrl_if #(.N_GHOSTS(NG), .N_FRUITS(NF), .COORD_W(CW), .SCORE_W(SW)) ifc ();
    pacman_game_ctrl_if #(.N_GHOSTS(NG), .N_FRUITS(NF), .COORD_W(CW), .SCORE_W(6))  ifc6 ();

    pacman_game_ctrl #(.N_GHOSTS(NG), .N_FRUITS(NF), .COORD_W(CW), .SCORE_W(SW), .FRUIT_POINTS(PTS),
                       .WIN_SCORE(WIN), .LIVES(LV), .RESPAWN_CYCLES(RC))
        dut (.Clk(Clk), .Reset_n(Reset_n), .bus(ifc));

    pacman_game_ctrl #(.N_GHOSTS(NG), .N_FRUITS(NF), .COORD_W(CW), .SCORE_W(6), .FRUIT_POINTS(50),
                       .WIN_SCORE(200), .LIVES(3), .RESPAWN_CYCLES(4))
        dut6 (.Clk(Clk), .Reset_n(Reset6_n), .bus(ifc6));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference game model: plain integers stepped once per clock from the game rules.
    int         m_mode, m_score, m_lives, m_cnt, m_idx;
    bit [NF-1:0] m_eaten;

    function automatic bit ov(input int ax, input int ay, input int as, input int bx, input int by, input int bs);
        return (ax < bx + bs) && (bx < ax + as) && (ay < by + bs) && (by < ay + as);
    endfunction

    task automatic model_reset();
        m_mode = M_RESTART; m_score = 0; m_eaten = '0; m_lives = LV; m_cnt = 0; m_idx = 0;
    endtask

    task automatic model_step();
        bit esc, mv, gh;
        int fi, px, py, ps;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        esc = (ifc.keycode == 8'h29);
        mv  = ifc.keycode inside {8'h04, 8'h07, 8'h16, 8'h1A};
        px = int'(ifc.pX); py = int'(ifc.pY); ps = int'(ifc.pSize);
        gh = 0;
        for (int g = 0; g < NG; g++)
            if (ov(px, py, ps, int'(ifc.gX[g*CW +: CW]), int'(ifc.gY[g*CW +: CW]), int'(ifc.gSize))) gh = 1;
        fi = -1;
        for (int f = NF - 1; f >= 0; f--)
            if (!m_eaten[f] && ov(px, py, ps, int'(ifc.fX[f*CW +: CW]), int'(ifc.fY[f*CW +: CW]), int'(ifc.fSize)))
                fi = f;
        case (m_mode)
            M_RESTART: begin m_score = 0; m_eaten = '0; m_lives = LV; m_mode = M_PAUSE; end
            M_PAUSE: if (mv) m_mode = M_RUN; else if (esc) m_mode = M_RESTART;
            M_RUN: begin
                if (esc) m_mode = M_RESTART;
                else if (m_score >= WIN) m_mode = M_WON;
                else if (gh) m_mode = M_DEATH;
                else if (fi >= 0) begin m_idx = fi; m_mode = M_EAT; end
            end
            M_EAT: begin
                m_eaten[m_idx] = 1'b1;
                m_score = (m_score + PTS > SMAX) ? SMAX : m_score + PTS;
                m_mode = M_RUN;
            end
            M_DEATH: begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_mode = M_OVER;
                else begin m_mode = M_RESPAWN; m_cnt = RC - 1; end
            end
            M_RESPAWN: begin
                if (esc) m_mode = M_RESTART;
                else if (m_cnt == 0) m_mode = M_PAUSE;
                else m_cnt = m_cnt - 1;
            end
            default: if (esc) m_mode = M_RESTART;
        endcase
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
    endtask

    task automatic set_pac(input int x, input int y);
        ifc.pX = CW'(x); ifc.pY = CW'(y);
    endtask

    task automatic set_ghost(input int i, input int x, input int y);
        ifc.gX[i*CW +: CW] = CW'(x); ifc.gY[i*CW +: CW] = CW'(y);
    endtask

    task automatic set_fruit(input int i, input int x, input int y);
        ifc.fX[i*CW +: CW] = CW'(x); ifc.fY[i*CW +: CW] = CW'(y);
    endtask

    task automatic park_all();
        ifc.pSize = 16; ifc.gSize = 16; ifc.fSize = 8;
        set_pac(50, 600);
        for (int g = 0; g < NG; g++) set_ghost(g, 900, 700 + 100 * g);
        for (int f = 0; f < NF; f++) set_fruit(f, 200 + 100 * f, 200);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; model_reset(); ifc.keycode = 8'h00; park_all();
        repeat (3) tick();
        n_checks++; if (ifc.restart !== 1'b1) begin n_fail++; $display("FAIL reset_restart: got %b expected 1", ifc.restart); end
        n_checks++; if ({ifc.running, ifc.win, ifc.lose, ifc.respawn, ifc.lifeDown} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {ifc.running, ifc.win, ifc.lose, ifc.respawn, ifc.lifeDown}); end
        n_checks++; if (ifc.score !== 10'd0 || ifc.lives !== 3'd3) begin n_fail++; $display("FAIL reset_regs: score %0d lives %0d expected 0 and 3", ifc.score, ifc.lives); end
        Reset_n = 1'b1;
        n_checks++; if (ifc.restart !== 1'b1) begin n_fail++; $display("FAIL release_restart: got %b expected 1", ifc.restart); end
        tick();
        n_checks++; if (ifc.restart !== 1'b0 || ifc.running !== 1'b0) begin n_fail++; $display("FAIL pause_flags: restart %b running %b expected 0 0", ifc.restart, ifc.running); end
        n_checks++; if (ifc.score !== 10'd0 || ifc.fruits_eaten !== 4'b0 || ifc.lives !== 3'd3) begin n_fail++; $display("FAIL pause_regs: score %0d eaten %b lives %0d expected 0 0000 3", ifc.score, ifc.fruits_eaten, ifc.lives); end
        ifc.keycode = KEY_D; tick(); ifc.keycode = 8'h00;
        n_checks++; if (ifc.running !== 1'b1) begin n_fail++; $display("FAIL start_run: got %b expected 1", ifc.running); end
    endtask

    task automatic test_fruit();
        set_pac(100, 100); set_fruit(2, 110, 110);
        tick();
        n_checks++; if (ifc.running !== 1'b0 || ifc.score !== 10'd0) begin n_fail++; $display("FAIL eat_cycle: running %b score %0d expected 0 0", ifc.running, ifc.score); end
        tick();
        n_checks++; if (ifc.fruits_eaten !== 4'b0100 || ifc.score !== 10'd50 || ifc.running !== 1'b1) begin n_fail++; $display("FAIL eat_result: eaten %b score %0d running %b expected 0100 50 1", ifc.fruits_eaten, ifc.score, ifc.running); end
        repeat (3) tick();
        n_checks++; if (ifc.score !== 10'd50 || ifc.running !== 1'b1) begin n_fail++; $display("FAIL eat_once: score %0d running %b expected 50 1", ifc.score, ifc.running); end
    endtask

    task automatic test_ghost_edge();
        int n, guard;
        set_ghost(1, 116, 100); tick();
        n_checks++; if (ifc.running !== 1'b1 || ifc.lifeDown !== 1'b0) begin n_fail++; $display("FAIL edge_touch: running %b lifeDown %b expected 1 0", ifc.running, ifc.lifeDown); end
        set_ghost(1, 115, 100); tick();
        n_checks++; if (ifc.lifeDown !== 1'b1 || ifc.lives !== 3'd3) begin n_fail++; $display("FAIL death: lifeDown %b lives %0d expected 1 3", ifc.lifeDown, ifc.lives); end
        set_ghost(1, 900, 800); tick();
        n_checks++; if (ifc.lifeDown !== 1'b0 || ifc.respawn !== 1'b1 || ifc.lives !== 3'd2) begin n_fail++; $display("FAIL respawn_entry: lifeDown %b respawn %b lives %0d expected 0 1 2", ifc.lifeDown, ifc.respawn, ifc.lives); end
        n = 1; guard = 0;
        while (ifc.respawn === 1'b1 && guard < 2000) begin
            tick(); guard++;
            if (ifc.respawn === 1'b1) n++;
        end
        n_checks++; if (n != RC) begin n_fail++; $display("FAIL respawn_len: got %0d cycles expected %0d", n, RC); end
        n_checks++; if (ifc.running !== 1'b0 || ifc.restart !== 1'b0 || ifc.score !== 10'd50) begin n_fail++; $display("FAIL after_respawn: running %b restart %b score %0d expected 0 0 50", ifc.running, ifc.restart, ifc.score); end
    endtask

    task automatic test_game_over();
        int guard;
        logic [7:0] k;
        for (int d = 0; d < 2; d++) begin
            ifc.keycode = KEY_A; tick(); ifc.keycode = 8'h00;
            set_ghost(0, 100, 100); tick();
            n_checks++; if (ifc.lifeDown !== 1'b1) begin n_fail++; $display("FAIL go_death%0d: lifeDown %b expected 1", d, ifc.lifeDown); end
            set_ghost(0, 900, 700); tick();
            if (d == 0) begin
                n_checks++; if (ifc.respawn !== 1'b1 || ifc.lives !== 3'd1) begin n_fail++; $display("FAIL go_respawn: respawn %b lives %0d expected 1 1", ifc.respawn, ifc.lives); end
                guard = 0;
                while (ifc.respawn === 1'b1 && guard < 2000) begin tick(); guard++; end
                n_checks++; if (ifc.respawn !== 1'b0) begin n_fail++; $display("FAIL go_respawn_end: respawn %b expected 0 after %0d cycles", ifc.respawn, guard); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            k = 8'($urandom_range(0, 255)); if (k == KEY_ESC) k = KEY_W;
            ifc.keycode = k; tick();
            n_checks++; if (ifc.lose !== 1'b1 || ifc.lives !== 3'd0 || ifc.running !== 1'b0) begin n_fail++; $display("FAIL game_over_hold: lose %b lives %0d running %b expected 1 0 0 (key %h)", ifc.lose, ifc.lives, ifc.running, k); end
        end
        ifc.keycode = KEY_ESC; tick(); ifc.keycode = 8'h00;
        n_checks++; if (ifc.restart !== 1'b1 || ifc.lose !== 1'b0) begin n_fail++; $display("FAIL over_restart: restart %b lose %b expected 1 0", ifc.restart, ifc.lose); end
        tick();
        n_checks++; if (ifc.lives !== 3'd3 || ifc.score !== 10'd0 || ifc.fruits_eaten !== 4'b0) begin n_fail++; $display("FAIL over_reload: lives %0d score %0d eaten %b expected 3 0 0000", ifc.lives, ifc.score, ifc.fruits_eaten); end
    endtask

    task automatic test_win();
        park_all(); ifc.keycode = KEY_D; tick(); ifc.keycode = 8'h00;
        for (int f = 0; f < NF; f++) begin
            set_pac(200 + 100 * f, 200); tick();
            set_pac(50, 600); tick();
            n_checks++; if (ifc.score !== 10'(PTS * (f + 1)) || ifc.fruits_eaten !== 4'((1 << (f + 1)) - 1) || ifc.running !== 1'b1) begin n_fail++; $display("FAIL win_eat%0d: score %0d eaten %b running %b expected %0d %b 1", f, ifc.score, ifc.fruits_eaten, ifc.running, PTS * (f + 1), 4'((1 << (f + 1)) - 1)); end
        end
        tick();
        n_checks++; if (ifc.win !== 1'b1 || ifc.running !== 1'b0) begin n_fail++; $display("FAIL win_level: win %b running %b expected 1 0", ifc.win, ifc.running); end
        ifc.keycode = KEY_S; repeat (3) tick();
        n_checks++; if (ifc.win !== 1'b1) begin n_fail++; $display("FAIL win_hold: win %b expected 1", ifc.win); end
        ifc.keycode = KEY_ESC; tick(); ifc.keycode = 8'h00; tick();
        n_checks++; if (ifc.win !== 1'b0 || ifc.score !== 10'd0) begin n_fail++; $display("FAIL win_restart: win %b score %0d expected 0 0", ifc.win, ifc.score); end
    endtask

    task automatic test_ghost_fruit();
        park_all(); ifc.keycode = KEY_S; tick(); ifc.keycode = 8'h00;
        set_pac(200, 200); set_ghost(0, 205, 205); tick();
        n_checks++; if (ifc.lifeDown !== 1'b1) begin n_fail++; $display("FAIL both_hit_death: lifeDown %b expected 1", ifc.lifeDown); end
        set_ghost(0, 900, 700); set_pac(50, 600); tick();
        n_checks++; if (ifc.respawn !== 1'b1 || ifc.fruits_eaten !== 4'b0 || ifc.score !== 10'd0 || ifc.lives !== 3'd2) begin n_fail++; $display("FAIL both_hit_keep: respawn %b eaten %b score %0d lives %0d expected 1 0000 0 2", ifc.respawn, ifc.fruits_eaten, ifc.score, ifc.lives); end
        tick(); tick();
        Reset_n = 1'b0; model_reset(); #1;
        n_checks++; if (ifc.restart !== 1'b1 || ifc.respawn !== 1'b0 || ifc.lives !== 3'd3) begin n_fail++; $display("FAIL async_reset: restart %b respawn %b lives %0d expected 1 0 3", ifc.restart, ifc.respawn, ifc.lives); end
        tick(); Reset_n = 1'b1; tick();
        n_checks++; if (ifc.restart !== 1'b0 || ifc.running !== 1'b0) begin n_fail++; $display("FAIL reset_to_pause: restart %b running %b expected 0 0", ifc.restart, ifc.running); end
    endtask

    task automatic test_saturate();
        int expv;
        Reset6_n = 1'b0;
        ifc6.keycode = 8'h00; ifc6.pSize = 16; ifc6.gSize = 16; ifc6.fSize = 8;
        ifc6.pX = CW'(50); ifc6.pY = CW'(600);
        for (int g = 0; g < NG; g++) begin ifc6.gX[g*CW +: CW] = CW'(900); ifc6.gY[g*CW +: CW] = CW'(700 + 100 * g); end
        for (int f = 0; f < NF; f++) begin ifc6.fX[f*CW +: CW] = CW'(200 + 100 * f); ifc6.fY[f*CW +: CW] = CW'(200); end
        tick(); tick(); Reset6_n = 1'b1; tick();
        ifc6.keycode = KEY_W; tick(); ifc6.keycode = 8'h00;
        for (int f = 0; f < 3; f++) begin
            ifc6.pX = CW'(200 + 100 * f); ifc6.pY = CW'(200); tick();
            ifc6.pX = CW'(50); ifc6.pY = CW'(600); tick();
            expv = (50 * (f + 1) > 63) ? 63 : 50 * (f + 1);
            n_checks++; if (ifc6.score !== 6'(expv)) begin n_fail++; $display("FAIL sat_score%0d: got %0d expected %0d", f, ifc6.score, expv); end
        end
        tick();
        n_checks++; if (ifc6.win !== 1'b0 || ifc6.running !== 1'b1) begin n_fail++; $display("FAIL sat_nowin: win %b running %b expected 0 1", ifc6.win, ifc6.running); end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] mv [4];
        mv[0] = KEY_W; mv[1] = KEY_A; mv[2] = KEY_S; mv[3] = KEY_D;
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 2) ifc.keycode = KEY_ESC;
            else if (r < 15) ifc.keycode = mv[$urandom_range(0, 3)];
            else if (r < 20) ifc.keycode = 8'($urandom_range(0, 255));
            else ifc.keycode = 8'h00;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 9) == 0) set_pac($urandom_range(980, 1023), $urandom_range(980, 1023));
                else set_pac($urandom_range(0, 300), $urandom_range(0, 300));
                ifc.pSize = CW'($urandom_range(1, 40));
                ifc.gSize = CW'($urandom_range(1, 30));
                ifc.fSize = CW'($urandom_range(1, 30));
                for (int g = 0; g < NG; g++) set_ghost(g, $urandom_range(0, 600), $urandom_range(0, 600));
                for (int f = 0; f < NF; f++) set_fruit(f, $urandom_range(0, 300), $urandom_range(0, 300));
            end
            Reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if (!Reset_n) model_reset();
            tick();
            n_checks++; if (ifc.score !== 10'(m_score)) begin n_fail++; $display("FAIL rnd_score c%0d: got %0d expected %0d", c, ifc.score, m_score); end
            n_checks++; if (ifc.fruits_eaten !== m_eaten) begin n_fail++; $display("FAIL rnd_eaten c%0d: got %b expected %b", c, ifc.fruits_eaten, m_eaten); end
            n_checks++; if (ifc.lives !== 3'(m_lives)) begin n_fail++; $display("FAIL rnd_lives c%0d: got %0d expected %0d", c, ifc.lives, m_lives); end
            n_checks++; if (ifc.running !== (m_mode == M_RUN)) begin n_fail++; $display("FAIL rnd_running c%0d: got %b expected %b", c, ifc.running, m_mode == M_RUN); end
            n_checks++; if (ifc.win !== (m_mode == M_WON)) begin n_fail++; $display("FAIL rnd_win c%0d: got %b expected %b", c, ifc.win, m_mode == M_WON); end
            n_checks++; if (ifc.lose !== (m_mode == M_OVER)) begin n_fail++; $display("FAIL rnd_lose c%0d: got %b expected %b", c, ifc.lose, m_mode == M_OVER); end
            n_checks++; if (ifc.restart !== (m_mode == M_RESTART)) begin n_fail++; $display("FAIL rnd_restart c%0d: got %b expected %b", c, ifc.restart, m_mode == M_RESTART); end
            n_checks++; if (ifc.respawn !== (m_mode == M_RESPAWN)) begin n_fail++; $display("FAIL rnd_respawn c%0d: got %b expected %b", c, ifc.respawn, m_mode == M_RESPAWN); end
            n_checks++; if (ifc.lifeDown !== (m_mode == M_DEATH)) begin n_fail++; $display("FAIL rnd_lifedown c%0d: got %b expected %b", c, ifc.lifeDown, m_mode == M_DEATH); end
        end
        Reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n  = 1'b0;
        Reset6_n = 1'b0;
        test_reset();
        test_fruit();
        test_ghost_edge();
        test_game_over();
        test_win();
        test_ghost_fruit();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
